seq_mdu: RTL and testbench
==========================

SEQ_MDU -- requirements
Module: seq_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; legal values 8..64, even.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to launch op when idle.
REQ-005 SHALL have port op  input  4  operation code (REQ-012).
REQ-006 SHALL have port a  input  WIDTH  operand A (dividend / multiplicand / mtXX source).
REQ-007 SHALL have port b  input  WIDTH  operand B (divisor / multiplier).
REQ-008 SHALL have port flush  input  1  abort in-flight op, suppress new launch (pipeline exception cancel).
REQ-009 SHALL have port sel  input  1  read select: 0 = LO, 1 = HI.
REQ-010 SHALL have port out  output  WIDTH  combinational read of LO or HI per sel.
REQ-011 SHALL have ports busy  output  1  op in progress; done  output  1  one-cycle completion pulse; dbz  output  1  one-cycle divide-by-zero pulse, coincident with done.

Function
REQ-012 SHALL decode op: 0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi, 7 madd, 8 maddu, 9 msub, 10 msubu; 11..15 treated as nop.
REQ-013 SHALL have FSM states IDLE, MUL, DIV, DONE; busy = 1 exactly in MUL and DIV.
REQ-014 SHALL accept start only in IDLE or DONE with flush = 0; start while busy ignored, no queuing.
REQ-015 SHALL, on accepted mult/multu/madd/maddu/msub/msubu, latch operands (signed ops: magnitudes plus result sign), enter MUL, perform one shift-add step per cycle for WIDTH cycles.
REQ-016 SHALL, on accepted div/divu with b != 0, latch operands, enter DIV, perform one restoring step per cycle for WIDTH cycles.
REQ-017 SHALL give latency: start sampled at edge E0, busy high for cycles after E0..EW (WIDTH cycles), HI/LO written at EW, busy low and done = 1 for the cycle after EW (state DONE), then IDLE.
REQ-018 SHALL compute mult/multu as full 2*WIDTH product into {HI,LO}; madd/maddu as {HI,LO} + product; msub/msubu as {HI,LO} - product; all modulo 2^(2*WIDTH); accumulate uses HI/LO value at EW.
REQ-019 SHALL compute div: LO = quotient truncated toward zero, HI = remainder with sign of dividend; divu unsigned.
REQ-020 SHALL, for div with a = most-negative, b = -1, write LO = most-negative, HI = 0, no dbz.
REQ-021 SHALL, for div/divu with b = 0, not enter DIV: HI/LO unchanged, busy never high, done = 1 and dbz = 1 in the cycle after E0.
REQ-022 SHALL execute mtlo/mthi in one edge (LO/HI <= a) when idle; no busy, no done; ignored while busy.
REQ-023 SHALL, on flush = 1 at any edge, return FSM to IDLE, leave HI/LO unchanged by the in-flight op, and suppress any start/mtXX sampled at that edge; done/dbz = 0 next cycle.
REQ-024 SHALL drive out = sel ? HI : LO at all times; during busy, out shows pre-op values.
REQ-025 SHALL allow back-to-back: start accepted in DONE cycle launches next op with no idle gap.

Reset
REQ-026 SHALL, on rst = 1 at an edge, clear HI, LO, iteration counter, datapath registers to 0, FSM to IDLE; busy, done, dbz = 0 next cycle; rst overrides flush and start, including mid-operation.

Verification
REQ-027 SHALL cover WIDTH=32 mult a=0xFFFFFFFE(-2), b=3 -> busy high 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done pulse 1 cycle.
REQ-028 SHALL cover div a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu same operands -> LO=0x7FFFFFFC, HI=1.
REQ-029 SHALL cover mthi 0, mtlo 10, then madd a=3, b=4 -> LO=22, HI=0; then msubu a=5, b=5 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-030 SHALL cover divu b=0 -> dbz and done high 1 cycle after start, busy never high, HI/LO unchanged.
REQ-031 SHALL cover flush at cycle 10 of multu 0xFFFFFFFF*0xFFFFFFFF -> busy low next cycle, HI/LO keep prior values, no done; start during busy ignored.
REQ-032 SHALL cover rst at cycle 5 of div -> HI=LO=0, busy=0 next cycle; also WIDTH=16 div 0x8000 / 0xFFFF -> LO=0x8000, HI=0, busy 16 cycles.

Source files
------------

// File: rtl/seq_mdu.sv
// Sequential multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one step per cycle over WIDTH cycles.
module seq_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTLO, OP_MTHI,
    OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
  } op_t;
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;

  state_t             state, state_nx;
  acc_t               acc_mode;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo, mcand, divisor, rem, quo;
  logic [2*WIDTH-1:0] prod;
  logic               neg, q_neg, r_neg, dbz_flag;

  logic               accept, op_smul, op_mul, op_sdiv, op_div, b_zero, last;
  logic [WIDTH-1:0]   a_op, b_op;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_nx, prod_signed, mul_res;
  logic [WIDTH-1:0]   rem_nx, quo_nx, q_res, r_res;

  always_comb begin
    accept  = ((state == IDLE) || (state == DONE)) && start && !flush;
    op_smul = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    op_mul  = op_smul || (op == OP_MULTU) || (op == OP_MADDU) || (op == OP_MSUBU);
    op_sdiv = (op == OP_DIV);
    op_div  = op_sdiv || (op == OP_DIVU);
    b_zero  = (b == '0);
    last    = (cnt == LAST);
    // Signed ops run on magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    a_op    = ((op_smul || op_sdiv) && a[WIDTH-1]) ? -a : a;
    b_op    = ((op_smul || op_sdiv) && b[WIDTH-1]) ? -b : b;
  end

  always_comb begin
    mul_sum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nx     = {mul_sum, prod[WIDTH-1:1]};
    prod_signed = neg ? -prod_nx : prod_nx;
    case (acc_mode)
      ACC_ADD: mul_res = {hi, lo} + prod_signed;
      ACC_SUB: mul_res = {hi, lo} - prod_signed;
      default: mul_res = prod_signed;
    endcase
    // Partial remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, divisor};
    div_ge    = !div_diff[WIDTH];
    rem_nx    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_nx    = {quo[WIDTH-2:0], div_ge};
    q_res     = q_neg ? -quo_nx : quo_nx;
    r_res     = r_neg ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (start) begin
          if (op_mul)      state_nx = MUL;
          else if (op_div) state_nx = b_zero ? DONE : DIV;
        end
      end
      MUL:     if (last) state_nx = DONE;
      DIV:     if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      mcand    <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      prod     <= '0;
      neg      <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dbz_flag <= 1'b0;
      acc_mode <= ACC_NONE;
    end else if (accept) begin
      dbz_flag <= op_div && b_zero;
      cnt      <= '0;
      if (op_mul) begin
        mcand <= a_op;
        prod  <= {{WIDTH{1'b0}}, b_op};
        neg   <= op_smul && (a[WIDTH-1] ^ b[WIDTH-1]);
        if ((op == OP_MADD) || (op == OP_MADDU))      acc_mode <= ACC_ADD;
        else if ((op == OP_MSUB) || (op == OP_MSUBU)) acc_mode <= ACC_SUB;
        else                                          acc_mode <= ACC_NONE;
      end else if (op_div && !b_zero) begin
        divisor <= b_op;
        quo     <= a_op;
        rem     <= '0;
        q_neg   <= op_sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg   <= op_sdiv && a[WIDTH-1];
      end else if (op == OP_MTLO) begin
        lo <= a;
      end else if (op == OP_MTHI) begin
        hi <= a;
      end
    end else if (!flush && (state == MUL)) begin
      prod <= prod_nx;
      cnt  <= cnt + 1'b1;
      if (last) {hi, lo} <= mul_res;
    end else if (!flush && (state == DIV)) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        lo <= q_res;
        hi <= r_res;
      end
    end
  end

  assign out  = sel ? hi : lo;
  assign busy = (state == MUL) || (state == DIV);
  assign done = (state == DONE);
  assign dbz  = (state == DONE) && dbz_flag;

endmodule

// File: tb/tb_seq_mdu.sv
// Directed plus randomized bench for seq_mdu against an arithmetic HI/LO model.
module tb_seq_mdu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, flush, sel, busy, done, dbz;
  logic [3:0]  op;
  logic [31:0] a, b, out;
  logic        start16, flush16, sel16, busy16, done16, dbz16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, out16;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi, m_lo;

  seq_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .sel(sel), .out(out), .busy(busy), .done(done), .dbz(dbz)
  );

  seq_mdu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16), .flush(flush16),
    .sel(sel16), .out(out16), .busy(busy16), .done(done16), .dbz(dbz16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    if (o == 4'd1 || o == 4'd7 || o == 4'd9) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'b0, x});
      sy = longint'({32'b0, y});
    end
    return 64'(sx * sy);
  endfunction

  task automatic ref_div(input bit s, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] q, output logic [31:0] r);
    longint sx, sy, lq, lr;
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    lq = sx / sy;
    lr = sx % sy;
    q = lq[31:0];
    r = lr[31:0];
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    sel = 1'b0; #1; l = out;
    sel = 1'b1; #1; h = out;
    sel = 1'b0; #1;
  endtask

  // Launches one op at posedge+1 and follows it to completion, flush or idle.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int flush_at, input bit poke, input bit hold);
    logic [31:0] exp_hi, exp_lo, rd_hi, rd_lo;
    logic [63:0] p;
    bit multi, zdiv, flushed;
    int n;
    exp_hi = m_hi; exp_lo = m_lo;
    zdiv  = (o == 4'd3 || o == 4'd4) && (y == 32'd0);
    multi = (o == 4'd1 || o == 4'd2 || (o >= 4'd7 && o <= 4'd10)) ||
            ((o == 4'd3 || o == 4'd4) && !zdiv);
    case (o)
      4'd1, 4'd2: begin p = ref_prod(o, x, y); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      4'd7, 4'd8: begin p = {m_hi, m_lo} + ref_prod(o, x, y); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      4'd9, 4'd10: begin p = {m_hi, m_lo} - ref_prod(o, x, y); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      4'd3, 4'd4: if (!zdiv) ref_div(o == 4'd3, x, y, exp_lo, exp_hi);
      4'd5: exp_lo = x;
      4'd6: exp_hi = x;
      default: ;
    endcase
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    if (multi) begin
      n = 0;
      flushed = 1'b0;
      while (busy && n < 100) begin
        n++;
        if (n == 1) chk("busy_out_preop", 64'(out), 64'(m_lo));
        if (poke && n == 3) begin start = 1'b1; op = 4'd5; a = ~m_lo; end
        if (flush_at != 0 && n == flush_at) flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        if (flush_at != 0 && n == flush_at) begin flushed = 1'b1; break; end
      end
      if (flushed) begin
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_done", 64'(done), 64'(0));
        read_hilo(rd_hi, rd_lo);
        chk("flush_hilo", {rd_hi, rd_lo}, {m_hi, m_lo});
        @(posedge clk); #1;
        chk("flush_no_done", 64'(done), 64'(0));
      end else begin
        chk("busy_cycles", 64'(n), 64'(32));
        chk("done_pulse", 64'(done), 64'(1));
        chk("dbz_low", 64'(dbz), 64'(0));
        read_hilo(rd_hi, rd_lo);
        chk("result_hilo", {rd_hi, rd_lo}, {exp_hi, exp_lo});
        m_hi = exp_hi; m_lo = exp_lo;
        if (!hold) begin
          @(posedge clk); #1;
          chk("done_one_cycle", 64'(done), 64'(0));
        end
      end
    end else if (zdiv) begin
      chk("dbz_busy", 64'(busy), 64'(0));
      chk("dbz_done", 64'(done), 64'(1));
      chk("dbz_flag", 64'(dbz), 64'(1));
      read_hilo(rd_hi, rd_lo);
      chk("dbz_hilo", {rd_hi, rd_lo}, {m_hi, m_lo});
      @(posedge clk); #1;
      chk("dbz_clear", 64'({done, dbz}), 64'(0));
    end else begin
      chk("mt_busy", 64'(busy), 64'(0));
      chk("mt_done", 64'(done), 64'(0));
      read_hilo(rd_hi, rd_lo);
      chk("mt_hilo", {rd_hi, rd_lo}, {exp_hi, exp_lo});
      m_hi = exp_hi; m_lo = exp_lo;
    end
  endtask

  initial begin
    logic [31:0] rh, rl, x, y;
    logic [3:0]  o;
    longint      q16, r16;
    int n;
    rst = 1'b1; start = 1'b0; flush = 1'b0; sel = 1'b0; op = '0; a = '0; b = '0;
    start16 = 1'b0; flush16 = 1'b0; sel16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    chk("reset_ctrl", 64'({busy, done, dbz}), 64'(0));
    read_hilo(rh, rl);
    chk("reset_hilo", {rh, rl}, 64'(0));

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 0, 1'b0, 1'b0);
    chk("mult_m2x3", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0);
    read_hilo(rh, rl);
    chk("div_m7_2", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'd4, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0);
    read_hilo(rh, rl);
    chk("divu_m7_2", {rh, rl}, 64'h0000_0001_7FFF_FFFC);

    run_op(4'd6, 32'd0, 32'd0, 0, 1'b0, 1'b0);
    run_op(4'd5, 32'd10, 32'd0, 0, 1'b0, 1'b0);
    run_op(4'd7, 32'd3, 32'd4, 0, 1'b0, 1'b0);
    read_hilo(rh, rl);
    chk("madd_acc", {rh, rl}, 64'd22);
    run_op(4'd10, 32'd5, 32'd5, 0, 1'b0, 1'b0);
    read_hilo(rh, rl);
    chk("msubu_acc", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(4'd4, 32'h1234_5678, 32'd0, 0, 1'b0, 1'b0);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
    read_hilo(rh, rl);
    chk("div_min_m1", {rh, rl}, 64'h0000_0000_8000_0000);

    run_op(4'd5, 32'hA5A5_0001, 32'd0, 0, 1'b0, 1'b0);
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 1'b1, 1'b0);
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 1'b0);
    chk("multu_max", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);

    start = 1'b1; op = 4'd5; a = 32'hDEAD_BEEF; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    read_hilo(rh, rl);
    chk("flush_blocks_mt", 64'(rl), 64'(m_lo));

    run_op(4'd1, 32'd7, 32'hFFFF_FFFD, 0, 1'b0, 1'b1);
    run_op(4'd3, 32'd100, 32'd7, 0, 1'b0, 1'b0);

    start = 1'b1; op = 4'd3; a = 32'h0BAD_F00D; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 5) begin
      n++;
      if (n == 5) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    chk("rst_mid_cycles", 64'(n), 64'(5));
    chk("rst_mid_ctrl", 64'({busy, done, dbz}), 64'(0));
    read_hilo(rh, rl);
    chk("rst_mid_hilo", {rh, rl}, 64'(0));
    m_hi = '0; m_lo = '0;

    start16 = 1'b1; op16 = 4'd3; a16 = 16'h8000; b16 = 16'hFFFF;
    q16 = longint'($signed(a16)) / longint'($signed(b16));
    r16 = longint'($signed(a16)) % longint'($signed(b16));
    @(posedge clk); #1;
    start16 = 1'b0;
    n = 0;
    while (busy16 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk("w16_busy_cycles", 64'(n), 64'(16));
    chk("w16_done", 64'(done16), 64'(1));
    sel16 = 1'b0; #1;
    chk("w16_lo", 64'(out16), 64'(q16[15:0]));
    sel16 = 1'b1; #1;
    chk("w16_hi", 64'(out16), 64'(r16[15:0]));
    sel16 = 1'b0;

    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 12));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: x = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(o, x, y, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 32)) : 0,
             $urandom_range(0, 4) == 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
